// File: rtl/alu_exec.sv
// Multi-cycle integer execute unit: aluop/funct decode, iterative shifts, optional
// shift-add multiplier with HI register (enabled by defining ALU_MULT_EN).
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

`ifdef ALU_MULT_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MULT, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif
  typedef enum logic [1:0] {K_SINGLE, K_SHIFT, K_MULT} kind_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shdir_t;

  state_t           state_q, state_d;
  kind_t            dec_kind;
  shdir_t           dec_sh, sh_q;
  logic [WIDTH-1:0] dec_val, result_q, shift_next;
  logic             dec_ill, illegal_q, lui_sel, accept;
  logic [5:0]       fn;
  logic [SHW:0]     cnt_q;
  logic             last_step;

`ifdef ALU_MULT_EN
  logic [2*WIDTH-1:0] p_q, p_next;
  logic [WIDTH-1:0]   mcand_q, hi_q;
  logic [WIDTH:0]     mult_sum;
`endif

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;
  assign last_step = (cnt_q == (SHW+1)'(1));

  // Fixed aluop codes are folded onto their funct equivalents so one table decodes both.
  always_comb begin
    lui_sel = 1'b0;
    fn      = funct;
    case (aluop)
      3'b000:  fn = 6'b100000;
      3'b001:  fn = 6'b100010;
      3'b010:  fn = 6'b101010;
      3'b011:  fn = 6'b100101;
      3'b110:  fn = 6'b100100;
      3'b101:  lui_sel = 1'b1;
      default: fn = funct;
    endcase
    dec_val  = '0;
    dec_ill  = 1'b0;
    dec_kind = K_SINGLE;
    dec_sh   = SH_LL;
    if (lui_sel) begin
      dec_val = b << (WIDTH/2);
    end else begin
      case (fn)
        6'b000000: begin dec_kind = K_SHIFT; dec_sh = SH_LL; end
        6'b000010: begin dec_kind = K_SHIFT; dec_sh = SH_RL; end
        6'b000011: begin dec_kind = K_SHIFT; dec_sh = SH_RA; end
        6'b100000: dec_val = a + b;
        6'b100010: dec_val = a - b;
        6'b100100: dec_val = a & b;
        6'b100101: dec_val = a | b;
        6'b100110: dec_val = a ^ b;
        6'b100111: dec_val = ~(a | b);
        6'b101010: dec_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        6'b101011: dec_val = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MULT_EN
        6'b011000: dec_kind = K_MULT;
        6'b010000: dec_val = hi_q;
`endif
        default:   dec_ill = 1'b1;
      endcase
    end
  end

  always_comb begin
    shift_next = result_q;
    case (sh_q)
      SH_LL:   shift_next = result_q << 1;
      SH_RL:   shift_next = result_q >> 1;
      SH_RA:   shift_next = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: shift_next = result_q;
    endcase
  end

`ifdef ALU_MULT_EN
  // Right-shifting product register: upper half accumulates, lower half holds the multiplier.
  always_comb begin
    mult_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    p_next   = {mult_sum, p_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          case (dec_kind)
            K_SHIFT: state_d = (shamt == '0) ? S_DONE : S_SHIFT;
`ifdef ALU_MULT_EN
            K_MULT:  state_d = S_MULT;
`endif
            default: state_d = S_DONE;
          endcase
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: if (last_step) state_d = S_DONE;
`ifdef ALU_MULT_EN
      S_MULT:  if (last_step) state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      sh_q      <= SH_LL;
`ifdef ALU_MULT_EN
      p_q       <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
`endif
    end else if (accept) begin
      illegal_q <= dec_ill;
      sh_q      <= dec_sh;
      case (dec_kind)
        K_SHIFT: begin
          result_q <= a;
          cnt_q    <= {1'b0, shamt};
        end
`ifdef ALU_MULT_EN
        K_MULT: begin
          p_q     <= {{WIDTH{1'b0}}, b};
          mcand_q <= a;
          cnt_q   <= (SHW+1)'(WIDTH);
        end
`endif
        default: result_q <= dec_val;
      endcase
    end else if (state_q == S_SHIFT) begin
      result_q <= shift_next;
      cnt_q    <= cnt_q - 1'b1;
`ifdef ALU_MULT_EN
    end else if (state_q == S_MULT) begin
      p_q   <= p_next;
      cnt_q <= cnt_q - 1'b1;
      if (last_step) begin
        result_q <= p_next[WIDTH-1:0];
        hi_q     <= p_next[2*WIDTH-1:WIDTH];
      end
`endif
    end
  end

endmodule
